// File: rtl/mau_pkg.sv
// -----------------------------------------------------------------------------
// mau_pkg
// Shared definitions for the load/store unit (mem_access_unit):
//   - RISC-V funct3 encodings for loads/stores
//   - FSM state enum
//   - byte-lane mask width and a lane-mask helper used by the store merge
// -----------------------------------------------------------------------------
package mau_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // One enable bit per byte lane of a 32-bit word.
   localparam int unsigned MAU_BE_W = 4;

   typedef enum logic {
      IDLE,
      RMW_WR
   } mau_state_e;

   // Byte lanes touched by an access of the given size at the given offset.
   // Halfwords select their lane pair by addr[1] only, so addr[0] is ignored.
   function automatic logic [MAU_BE_W-1:0] be_mask(input logic [2:0] f3,
                                                   input logic [1:0] a);
      logic [MAU_BE_W-1:0] m;
      case (f3)
         F3_B, F3_BU: m = MAU_BE_W'(1) << a;
         F3_H, F3_HU: m = a[1] ? 4'b1100 : 4'b0011;
         default:     m = 4'b1111;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// -----------------------------------------------------------------------------
// mau_load_align
// Combinational load-data aligner: picks the addressed byte/halfword out of a
// memory word and sign- or zero-extends it according to funct3.
// Ports:
//   word_i    in  32  raw memory word
//   addr_i    in  2   byte offset within the word
//   funct3_i  in  3   load type (B, H, W, BU, HU)
//   data_o    out 32  aligned, extended load result
// -----------------------------------------------------------------------------
module mau_load_align
   import mau_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  addr_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word_i[{addr_i, 3'b000} +: 8];
      half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
      case (funct3_i)
         F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   data_o = {24'b0, byte_sel};
         F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
         F3_HU:   data_o = {16'b0, half_sel};
         default: data_o = word_i;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Load/store unit between execute and a word-organised data memory
// (combinational read, posedge write). Loads return extended data one cycle
// after acceptance; SW writes in one cycle; SB/SH run a read-modify-write
// (read+merge in IDLE, write in RMW_WR with stall raised).
// Optional feature macro: MAU_MISALIGN_CHECK_EN -- when defined, misaligned
// H/HU/SH and W/SW accesses fault instead of silently dropping low address bits.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/write/funct3/addr/wdata   request from execute
//   stall                      request not accepted this cycle
//   rsp_valid, rsp_rdata       load response (one-cycle pulse)
//   fault                      illegal/misaligned request (one-cycle pulse)
//   mem_read, mem_write, mem_addr, mem_wdata, mem_rdata   data-memory port
// -----------------------------------------------------------------------------
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              stall,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              fault,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   mau_state_e        state_q, state_d;
   logic [DATA_W-1:0] merge_q, merge_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              fault_q, fault_d;

   logic              rd_en, wr_en;
   logic              illegal, misalign;
   logic [DATA_W-1:0] ld_data;
   logic [ADDR_W-1:0] req_word_addr;

   // Replace the target lane(s) of the old word with the store data.
   function automatic logic [DATA_W-1:0] merge_lane(input logic [DATA_W-1:0] old,
                                                    input logic [DATA_W-1:0] wd,
                                                    input logic [2:0]        f3,
                                                    input logic [1:0]        a);
      logic [MAU_BE_W-1:0] be;
      logic [DATA_W-1:0]   src;
      logic [DATA_W-1:0]   m;
      be  = be_mask(f3, a);
      src = (f3 == F3_B) ? {4{wd[7:0]}} : {2{wd[15:0]}};
      m   = old;
      for (int i = 0; i < MAU_BE_W; i++) begin
         if (be[i]) m[8*i +: 8] = src[8*i +: 8];
      end
      return m;
   endfunction

   assign req_word_addr = {req_addr[ADDR_W-1:2], 2'b00};

   always_comb begin
      if (req_write)
         illegal = !(req_funct3 inside {F3_B, F3_H, F3_W});
      else
         illegal = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
`ifdef MAU_MISALIGN_CHECK_EN
      misalign = ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0]) ||
                 ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
`else
      misalign = 1'b0;
`endif
   end

   mau_load_align u_load_align (
      .word_i   (mem_rdata),
      .addr_i   (req_addr[1:0]),
      .funct3_i (req_funct3),
      .data_o   (ld_data)
   );

   always_comb begin
      state_d     = state_q;
      merge_d     = merge_q;
      addr_d      = addr_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_valid_d = 1'b0;
      fault_d     = 1'b0;
      stall       = 1'b0;
      rd_en       = 1'b0;
      wr_en       = 1'b0;
      mem_addr    = req_word_addr;
      mem_wdata   = req_wdata;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (illegal || misalign) begin
                  fault_d = 1'b1;
               end else if (!req_write) begin
                  rd_en       = 1'b1;
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = ld_data;
               end else if (req_funct3 == F3_W) begin
                  wr_en = 1'b1;
               end else begin
                  rd_en   = 1'b1;
                  merge_d = merge_lane(mem_rdata, req_wdata, req_funct3, req_addr[1:0]);
                  addr_d  = req_word_addr;
                  state_d = RMW_WR;
               end
            end
         end
         RMW_WR: begin
            stall     = 1'b1;
            wr_en     = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = merge_q;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset gates the enables combinationally so no access leaks out while held.
   assign mem_read  = rst_n & rd_en;
   assign mem_write = rst_n & wr_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         merge_q     <= '0;
         addr_q      <= '0;
         rsp_rdata_q <= '0;
         rsp_valid_q <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         merge_q     <= merge_d;
         addr_q      <= addr_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_valid_q <= rsp_valid_d;
         fault_q     <= fault_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign fault     = fault_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit between the execute stage and the word-organised data memory. Accepts RISC-V byte/halfword/word loads and stores, drives the data-memory port (combinational read, posedge write, word-indexed by byte address), and returns aligned, sign- or zero-extended load data one cycle later. Sub-word stores are done as a two-cycle read-modify-write, because the memory writes whole words only.

## Interface
- ADDR_W, 6: byte-address width of the data-memory port.
- DATA_W, 32: data width; only 32 is supported.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data (rs2).
- stall  out  1  request presented this cycle is not accepted; hold it.
- rsp_valid  out  1  one-cycle pulse; rsp_rdata holds valid load data.
- rsp_rdata  out  32  extended load result.
- fault  out  1  one-cycle pulse: misaligned or illegal funct3.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_addr  out  ADDR_W  word-aligned byte address, {addr[ADDR_W-1:2], 2'b00}.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  combinational read data.

## Operation
- Accept = req_valid && !stall. A request is handled only in the cycle it is accepted.
- FSM states: IDLE, RMW_WR. Reset puts the FSM in IDLE.
- IDLE, load accepted:
  - mem_read = 1 in the same cycle.
  - Lane select and extension: B/BU select byte addr[1:0]; H/HU select half addr[1]. B and H sign-extend; BU and HU zero-extend.
  - Result is registered into rsp_rdata. State stays IDLE.
- IDLE, SW accepted: mem_write = 1 and mem_wdata = req_wdata in the same cycle. Done in one cycle; state stays IDLE.
- IDLE, SB/SH accepted:
  - mem_read = 1 in the same cycle.
  - Merge register captures mem_rdata with the target lane replaced by req_wdata[7:0] or [15:0].
  - Word address is latched. Go to RMW_WR.
- RMW_WR:
  - mem_write = 1, mem_addr = latched address, mem_wdata = merge register.
  - stall = 1; req inputs are ignored. Go to IDLE.
- Illegal funct3:
  - Store: 100, 101, 011, 11x.
  - Load: 011, 11x.
  - Response: no memory access, fault pulse, no rsp.
- Misaligned access: behaviour is set by the macro under Configuration.
- Memory enables are gated by rst_n: mem_read = mem_write = 0 while rst_n = 0.

## Timing
- Reset values: stall 0, rsp_valid 0, rsp_rdata 0, fault 0, mem_read 0, mem_write 0, merge register 0.
- Load latency: accept in cycle N; rsp_valid = 1 in cycle N+1 only.
- fault: asserted in cycle N+1 for a request accepted in cycle N.
- SW: written at the edge ending cycle N.
- SB/SH:
  - Cycle N: read.
  - Cycle N+1: write, with stall = 1.
  - The next request is accepted no earlier than cycle N+2.
- Back-to-back loads or SWs: one per cycle with no stall.
- Load in cycle N+2 after a sub-word store to the same word returns the merged value.
- rst_n low mid-RMW (in RMW_WR): no write is issued, the memory word is unchanged, and the FSM is in IDLE on release.

## Configuration
- MAU_MISALIGN_CHECK_EN defined:
  - Misaligned accesses are H/HU/SH with addr[0] = 1, and W/SW with addr[1:0] != 0.
  - Response: no memory access, fault pulse at N+1, no rsp.
- MAU_MISALIGN_CHECK_EN undefined:
  - Misalignment is never flagged; fault is asserted only for illegal funct3.
  - H/HU/SH ignore addr[0]; W/SW ignore addr[1:0].

## Structure
- Package mau_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum (IDLE, RMW_WR).
  - Byte-lane mask width constant.
- Sub-module mau_load_align: combinational. Inputs: 32-bit word, addr[1:0], funct3. Output: extended 32-bit value. It is used on the load path.

## Test plan
- Reset: rst_n = 0 with req_valid = 1, SW -> all outputs 0 and no mem_write; after release, the first request is accepted.
- LW to 0x04, memory word 0x1234_5678 -> rsp_valid at N+1, rsp_rdata = 0x1234_5678, stall never 1.
- Byte loads to 0x07, memory word 0x80FF_0011 -> LB gives 0xFFFF_FF80; LBU gives 0x0000_0080.
- Sub-word store then load:
  - SB to 0x05, wdata 0xAAAA_AA5A, old word 0x1122_3344 -> cycle N mem_read; cycle N+1 mem_write with mem_wdata = 0x1122_5A44 and stall = 1.
  - LW to 0x04 presented at N+1 is accepted at N+2 and returns 0x1122_5A44.
- SH to 0x03, wdata 0xBEEF:
  - With macro -> fault at N+1, no mem_write, no rsp_valid.
  - Without macro -> word 0 upper half = 0xBEEF.
- rst_n asserted during RMW_WR of SB to 0x00 -> mem_write never 1 and word 0 unchanged; illegal store funct3 100 -> fault at N+1 and no memory access.
